alu_arbiter_ctrl: RTL and testbench
===================================

# alu_arbiter_ctrl

Sequencing and arbitration controller that shares one combinational 128-bit ALU between two requesters. It grants requests round-robin and drives the ALU operand and opcode ports from registered values. It holds those operands stable for a programmable multicycle window on DIV, then returns result and flags through a backpressured response channel. It also resolves compare opcodes and illegal opcodes locally.

## Interface
- WIDTH, 128, operand/result width; must match the ALU instance
- DIV_CYCLES, 4, cycles operands are held for DIV (multicycle path); legal range 1..15
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  request valid, per port
- req0_ready / req1_ready  out  1  request accepted this cycle; combinational, at most one high
- req0_opcode / req1_opcode  in  4  opcode: ADD=0 SUB=1 AND=2 OR=3 SLL=4 NAND=5 SNE=6 SLTU=7 SLT=8 DIV=9 SRL=10
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_shamt / req1_shamt  in  5  shift amount
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  1  requester index of the response
- rsp_result  out  WIDTH  result
- rsp_carry, rsp_zero, rsp_sign, rsp_err  out  1 each  flags; err = illegal opcode
- alu_opcode  out  4  to ALU
- alu_input1, alu_input2  out  WIDTH  to ALU
- alu_shiftValue  out  5  to ALU
- alu_result  in  WIDTH  from ALU
- alu_carryFlag, alu_zeroFlag, alu_signFlag  in  1 each  from ALU

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE, with at least one valid request:
  - Grant one port and assert its ready for that cycle.
  - Latch opcode, a, b and shamt into the operand registers; latch the port index into the id register.
  - Next state is EXEC with the counter loaded to DIV_CYCLES-1 for DIV and 0 otherwise.
  - Illegal opcodes (11..15) skip EXEC and go straight to RESP.
- Arbitration: round-robin with a 1-bit priority pointer.
  - If both ports are valid, the pointer port wins.
  - After any grant, the pointer moves to the other port.
  - If only one port is valid, that port wins; the pointer still updates to the non-granted port.
  - Pointer resets to 0.
- alu_* outputs are driven directly from the operand registers, so they are stable for the whole EXEC window.
- EXEC: decrement the counter each cycle. When it reaches 0, capture the response and go to RESP.
- Response capture:
  - Opcodes 0–5, 9, 10: rsp_result = alu_result; zero and sign are computed locally from the captured result.
  - rsp_carry = alu_carryFlag for ADD/SUB only, else 0.
  - SNE/SLTU/SLT: result is computed locally from the operand registers as {WIDTH-1 zeros, cond}. SNE is a≠b, SLTU is unsigned a<b, SLT is signed a<b. carry=0 and sign=0; zero = !cond.
  - DIV with b==0: result 0, zero=1, err=0.
  - Illegal opcode: result 0, carry=0, zero=1, sign=0, err=1.
- RESP: rsp_valid=1 and all rsp_* fields held stable. On rsp_ready=1, next state is IDLE. No request is granted while in EXEC or RESP.
- Reset (any state, including mid-EXEC or RESP):
  - Next edge forces IDLE and pointer 0.
  - All rsp_* and operand/id registers go to 0 (alu_* outputs therefore read 0).
  - The in-flight request is dropped with no response.

## Timing
- Request accepted at edge T (ready high in cycle T).
- Non-DIV ops: one EXEC cycle; rsp_valid rises in cycle T+2.
- DIV: rsp_valid rises in cycle T+1+DIV_CYCLES.
- Illegal opcode: rsp_valid rises in cycle T+1.
- rsp_ready high in the first RESP cycle gives a one-cycle rsp_valid pulse. The next grant is possible in the following cycle (IDLE).
- Peak throughput: one op per 3 cycles for non-DIV ops.
- Ready depends combinationally on valid, state and pointer only, never on ready.
- Reset values: req*_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, all rsp flags 0, alu_* 0.

## Test plan
- Reset then ADD from port 0 with a=5, b=7: ready0 high one cycle; rsp_valid at T+2 with result 12, id 0, zero 0, carry from ALU.
- Both ports valid from reset, SUB on each: port 0 served first, then port 1. Hold both valid for 4 ops: grant order 0,1,0,1.
- DIV, DIV_CYCLES=4, a=100, b=7: alu_input1/2 stable T+1..T+4; rsp at T+5 result 14. Repeat with b=0: result 0, zero 1, err 0.
- SLT with a=all-ones, b=1 → result 1. SLTU with the same operands → result 0, zero 1. SNE with a=b=3 → result 0.
- Opcode 13: rsp at T+1 with err 1, result 0. Hold rsp_ready=0 for 5 cycles: fields stable, no new grant while req1_valid is high.
- Assert rst_n=0 mid-DIV (EXEC): next cycle IDLE, all outputs 0, no response. The following request is granted to port 0.

Source files
------------

// File: rtl/alu_arbiter_ctrl.sv
// Two-port round-robin front end for a shared combinational ALU.
// Holds operands across a multicycle DIV window and resolves compares locally.
module alu_arbiter_ctrl #(
    parameter int WIDTH      = 128,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [4:0]       req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [4:0]       req1_shamt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_sign,
    output logic             rsp_err,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryFlag,
    input  logic             alu_zeroFlag,
    input  logic             alu_signFlag
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_SNE  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;

    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    logic [1:0]       state;
    logic             ptr;
    logic [3:0]       cnt;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [4:0]       sh_r;
    logic             id_r;

    logic             idle;
    logic             gnt0;
    logic             gnt1;
    logic             grant;
    logic [3:0]       g_op;
    logic             g_illegal;
    logic [WIDTH-1:0] c_res;
    logic             c_carry;

    // ALU flags for zero/sign are recomputed from the captured result
    logic unused_flags;
    assign unused_flags = alu_zeroFlag ^ alu_signFlag;

    assign idle       = (state == IDLE);
    assign gnt1       = req1_valid & (~req0_valid | ptr);
    assign gnt0       = req0_valid & ~gnt1;
    assign req0_ready = idle & gnt0;
    assign req1_ready = idle & gnt1;
    assign grant      = req0_ready | req1_ready;
    assign g_op       = gnt1 ? req1_opcode : req0_opcode;
    assign g_illegal  = (g_op > OP_SRL);

    assign rsp_valid      = (state == RESP);
    assign alu_opcode     = op_r;
    assign alu_input1     = a_r;
    assign alu_input2     = b_r;
    assign alu_shiftValue = sh_r;

    always_comb begin
        c_res   = '0;
        c_carry = 1'b0;
        case (op_r)
            OP_ADD, OP_SUB: begin
                c_res   = alu_result;
                c_carry = alu_carryFlag;
            end
            OP_AND, OP_OR, OP_SLL, OP_NAND, OP_SRL:
                c_res = alu_result;
            OP_DIV:
                c_res = (b_r == '0) ? '0 : alu_result;
            OP_SNE:
                c_res = {{(WIDTH-1){1'b0}}, a_r != b_r};
            OP_SLTU:
                c_res = {{(WIDTH-1){1'b0}}, a_r < b_r};
            OP_SLT:
                c_res = {{(WIDTH-1){1'b0}}, $signed(a_r) < $signed(b_r)};
            default: c_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cnt        <= '0;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            sh_r       <= '0;
            id_r       <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        op_r <= g_op;
                        a_r  <= gnt1 ? req1_a : req0_a;
                        b_r  <= gnt1 ? req1_b : req0_b;
                        sh_r <= gnt1 ? req1_shamt : req0_shamt;
                        id_r <= gnt1;
                        ptr  <= gnt0;
                        // Illegal opcodes never touch the ALU
                        if (g_illegal) begin
                            state      <= RESP;
                            rsp_id     <= gnt1;
                            rsp_result <= '0;
                            rsp_carry  <= 1'b0;
                            rsp_zero   <= 1'b1;
                            rsp_sign   <= 1'b0;
                            rsp_err    <= 1'b1;
                        end else begin
                            state <= EXEC;
                            cnt   <= (g_op == OP_DIV) ? DIV_LOAD : 4'd0;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        rsp_id     <= id_r;
                        rsp_result <= c_res;
                        rsp_carry  <= c_carry;
                        rsp_zero   <= (c_res == '0);
                        rsp_sign   <= c_res[WIDTH-1];
                        rsp_err    <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl with a behavioural ALU and a spec-level
// response model; directed steps followed by randomized transactions.
module tb_alu_arbiter_ctrl;

    localparam int W  = 128;
    localparam int DC = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         s;
        logic         e;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_opcode, req1_opcode;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]   req0_shamt, req1_shamt;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_carry, rsp_zero, rsp_sign, rsp_err;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_input1, alu_input2, alu_result;
    logic [4:0]   alu_shiftValue;
    logic         alu_carryFlag, alu_zeroFlag, alu_signFlag;
    logic [2:0]   noise = 3'b0;

    int checks = 0;
    int errors = 0;
    bit ptr = 1'b0;

    logic [3:0]   op_t[2];
    logic [W-1:0] a_t[2];
    logic [W-1:0] b_t[2];
    logic [4:0]   sh_t[2];

    alu_arbiter_ctrl #(.WIDTH(W), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
        .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
        .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1),
        .alu_input2(alu_input2), .alu_shiftValue(alu_shiftValue),
        .alu_result(alu_result), .alu_carryFlag(alu_carryFlag),
        .alu_zeroFlag(alu_zeroFlag), .alu_signFlag(alu_signFlag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) noise <= 3'($urandom);

    // Shared ALU; non-ALU opcodes and DIV-by-zero return junk on purpose
    always_comb begin
        alu_result    = '1;
        alu_carryFlag = noise[0];
        alu_zeroFlag  = noise[1];
        alu_signFlag  = noise[2];
        case (alu_opcode)
            4'd0: {alu_carryFlag, alu_result} = {1'b0, alu_input1} + {1'b0, alu_input2};
            4'd1: {alu_carryFlag, alu_result} = {1'b0, alu_input1} - {1'b0, alu_input2};
            4'd2: alu_result = alu_input1 & alu_input2;
            4'd3: alu_result = alu_input1 | alu_input2;
            4'd4: alu_result = alu_input1 << alu_shiftValue;
            4'd5: alu_result = ~(alu_input1 & alu_input2);
            4'd9: if (alu_input2 != '0) alu_result = alu_input1 / alu_input2;
            4'd10: alu_result = alu_input1 >> alu_shiftValue;
            default: ;
        endcase
    end

    function automatic rsp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [4:0] sh);
        rsp_t r;
        logic [W:0] wide;
        r = '0;
        case (op)
            4'd0: begin wide = {1'b0, a} + {1'b0, b}; r.res = wide[W-1:0]; r.c = wide[W]; end
            4'd1: begin wide = {1'b0, a} - {1'b0, b}; r.res = wide[W-1:0]; r.c = wide[W]; end
            4'd2: r.res = a & b;
            4'd3: r.res = a | b;
            4'd4: r.res = a << sh;
            4'd5: r.res = ~(a & b);
            4'd6: r.res = (a != b) ? 1 : 0;
            4'd7: r.res = (a < b) ? 1 : 0;
            4'd8: r.res = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd9: r.res = (b == 0) ? 0 : a / b;
            4'd10: r.res = a >> sh;
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 0);
        r.s = r.res[W-1];
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit v1);
        req0_opcode = op_t[0]; req0_a = a_t[0]; req0_b = b_t[0]; req0_shamt = sh_t[0];
        req1_opcode = op_t[1]; req1_a = a_t[1]; req1_b = b_t[1]; req1_shamt = sh_t[1];
        req0_valid = v0;
        req1_valid = v1;
    endtask

    task automatic check_reset_values();
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_flags", {rsp_carry, rsp_zero, rsp_sign, rsp_err}, 0);
        check("rst_alu_op", alu_opcode, 0);
        check("rst_alu_in1", alu_input1, 0);
        check("rst_alu_in2", alu_input2, 0);
        check("rst_alu_sh", alu_shiftValue, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        ptr = 1'b0;
    endtask

    // One request through grant, execute, response and handshake
    task automatic txn(input bit v0, input bit v1, input int hold);
        bit   w;
        rsp_t e;
        int   lat;
        int   elat;
        w = (v0 && v1) ? ptr : v1;
        ptr = !w;
        e = model(op_t[w], a_t[w], b_t[w], sh_t[w]);
        elat = (op_t[w] > 10) ? 1 : ((op_t[w] == 9) ? 1 + DC : 2);
        drive(v0, v1);
        #1;
        check("grant0", req0_ready, (w == 1'b0));
        check("grant1", req1_ready, (w == 1'b1));
        lat = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
            if (!rsp_valid) begin
                check("busy_ready", {req0_ready, req1_ready}, 0);
                check("exec_in1", alu_input1, a_t[w]);
                check("exec_in2", alu_input2, b_t[w]);
                check("exec_op", alu_opcode, op_t[w]);
            end
        end while (!rsp_valid && lat < 30);
        check("latency", lat, elat);
        check("rsp_id", rsp_id, w);
        check("rsp_result", rsp_result, e.res);
        check("rsp_carry", rsp_carry, e.c);
        check("rsp_zero", rsp_zero, e.z);
        check("rsp_sign", rsp_sign, e.s);
        check("rsp_err", rsp_err, e.e);
        check("alu_sh", alu_shiftValue, sh_t[w]);
        repeat (hold) begin
            @(negedge clk);
            #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, e.res);
            check("hold_flags", {rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_err},
                  {w, e.c, e.z, e.s, e.e});
            check("hold_ready", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("rsp_drop", rsp_valid, 0);
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_t[i] = '0; a_t[i] = '0; b_t[i] = '0; sh_t[i] = '0;
        end
        drive(1'b0, 1'b0);
        @(negedge clk);
        do_reset();

        op_t[0] = 4'd0; a_t[0] = 5; b_t[0] = 7;
        txn(1'b1, 1'b0, 0);

        do_reset();
        op_t[0] = 4'd1; a_t[0] = 20; b_t[0] = 3;
        op_t[1] = 4'd1; a_t[1] = 2;  b_t[1] = 9;
        repeat (4) txn(1'b1, 1'b1, 0);

        op_t[0] = 4'd9; a_t[0] = 100; b_t[0] = 7;
        txn(1'b1, 1'b0, 0);
        b_t[0] = 0;
        txn(1'b1, 1'b0, 0);

        op_t[0] = 4'd8; a_t[0] = '1; b_t[0] = 1;
        txn(1'b1, 1'b0, 0);
        op_t[0] = 4'd7;
        txn(1'b1, 1'b0, 0);
        op_t[0] = 4'd6; a_t[0] = 3; b_t[0] = 3;
        txn(1'b1, 1'b0, 0);

        op_t[0] = 4'd13; op_t[1] = 4'd13;
        txn(1'b1, 1'b1, 5);

        // Reset while a DIV is in its hold window
        op_t[0] = 4'd9; a_t[0] = 1000; b_t[0] = 3; sh_t[0] = 5'd7;
        drive(1'b1, 1'b0);
        #1;
        check("div_grant", req0_ready, 1);
        repeat (2) @(negedge clk);
        #1;
        check("div_busy", rsp_valid, 0);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        ptr = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            check("no_rsp_after_rst", rsp_valid, 0);
        end
        op_t[0] = 4'd0; a_t[0] = 11; b_t[0] = 22;
        op_t[1] = 4'd3; a_t[1] = 12; b_t[1] = 48;
        txn(1'b1, 1'b1, 0);

        for (int n = 0; n < 60; n++) begin
            int  pick;
            bit  v0;
            bit  v1;
            for (int i = 0; i < 2; i++) begin
                op_t[i] = 4'($urandom_range(0, 15));
                a_t[i]  = rnd128();
                b_t[i]  = ($urandom_range(0, 3) == 0) ? a_t[i] : rnd128();
                if (op_t[i] == 4'd9 && $urandom_range(0, 2) == 0)
                    b_t[i] = W'($urandom_range(0, 5));
                sh_t[i] = 5'($urandom);
            end
            pick = $urandom_range(1, 3);
            v0 = pick[0];
            v1 = pick[1];
            txn(v0, v1, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
